// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// fft_frame_ctrl - frames a valid/ready sample stream into N-cycle FFT64 bursts
//                  and marks/monitors the FFT output stream.
// Revision: 1.0
// ============================================================================
module fft_frame_ctrl #(
  parameter int N            = 64,
  parameter int LOG2N        = 6,
  parameter int WIDTH        = 16,
  parameter int MAX_INFLIGHT = 2,
  parameter int TIMEOUT      = 512
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic             m_first,
  output logic             m_last,
  output logic [1:0]       inflight,
  output logic             err_spurious,
  output logic             err_timeout
);

  localparam int              c_pw           = LOG2N + 1;
  localparam int              c_cw           = LOG2N + 2;
  localparam int              c_tw           = $clog2(TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_depth        = c_cw'(2 * N);
  localparam logic [c_cw-1:0] c_n            = c_cw'(N);
  localparam logic [LOG2N-1:0] c_last        = LOG2N'(N - 1);
  localparam logic [c_tw-1:0] c_timeout      = c_tw'(TIMEOUT);
  localparam logic [1:0]      c_max_inflight = 2'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mem_q [2*N];
  logic [c_pw-1:0]      wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]      rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]      count_q, count_d;
  logic [LOG2N-1:0]     bcnt_q, bcnt_d;
  logic [LOG2N-1:0]     oc_q, oc_d;
  logic [1:0]           inflight_q, inflight_d;
  logic [c_tw-1:0]      idle_q, idle_d;
  logic                 di_en_q, di_en_d;
  logic [WIDTH-1:0]     di_re_q, di_re_d;
  logic [WIDTH-1:0]     di_im_q, di_im_d;
  logic                 m_valid_q, m_valid_d;
  logic [WIDTH-1:0]     m_re_q, m_re_d;
  logic [WIDTH-1:0]     m_im_q, m_im_d;
  logic                 m_first_q, m_first_d;
  logic                 m_last_q, m_last_d;
  logic                 err_sp_q, err_sp_d;
  logic                 err_to_q, err_to_d;
  logic                 push, pop, start, frame_done;
  logic [2*WIDTH-1:0]   rd_word;

  assign s_ready = (count_q < c_depth);
  assign rd_word = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_re, s_im};
    end
  end

  // The first pop happens on the decision edge so di_en rises the cycle after it;
  // the BURST cycle presenting sample N-1 is followed by one FILL cycle.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    pop     = 1'b0;
    start   = 1'b0;
    case (state_q)
      FILL: begin
        if ((count_q >= c_n) && (inflight_q < c_max_inflight)) begin
          state_d = BURST;
          bcnt_d  = '0;
          pop     = 1'b1;
          start   = 1'b1;
        end
      end
      BURST: begin
        if (bcnt_q == c_last) begin
          state_d = FILL;
        end else begin
          pop    = 1'b1;
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    push     = s_valid && s_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    di_en_d = pop;
    di_re_d = pop ? rd_word[2*WIDTH-1:WIDTH] : di_re_q;
    di_im_d = pop ? rd_word[WIDTH-1:0]       : di_im_q;

    frame_done = fft_do_en && (oc_q == c_last);
    oc_d       = oc_q;
    if (fft_do_en) begin
      oc_d = frame_done ? '0 : oc_q + 1'b1;
    end
    m_valid_d = fft_do_en;
    m_re_d    = fft_do_re;
    m_im_d    = fft_do_im;
    m_first_d = fft_do_en && (oc_q == '0);
    m_last_d  = frame_done;

    inflight_d = inflight_q;
    case ({start, frame_done})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = (inflight_q != 2'd0) ? inflight_q - 1'b1 : inflight_q;
      default: inflight_d = inflight_q;
    endcase

    err_sp_d = err_sp_q | (fft_do_en && (inflight_q == 2'd0));

    idle_d = idle_q;
    if (fft_do_en || (inflight_q == 2'd0)) begin
      idle_d = '0;
    end else if (idle_q != c_timeout) begin
      idle_d = idle_q + 1'b1;
    end
    err_to_d = err_to_q | (idle_d == c_timeout);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bcnt_q     <= '0;
      oc_q       <= '0;
      inflight_q <= '0;
      idle_q     <= '0;
      di_en_q    <= 1'b0;
      di_re_q    <= '0;
      di_im_q    <= '0;
      m_valid_q  <= 1'b0;
      m_re_q     <= '0;
      m_im_q     <= '0;
      m_first_q  <= 1'b0;
      m_last_q   <= 1'b0;
      err_sp_q   <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bcnt_q     <= bcnt_d;
      oc_q       <= oc_d;
      inflight_q <= inflight_d;
      idle_q     <= idle_d;
      di_en_q    <= di_en_d;
      di_re_q    <= di_re_d;
      di_im_q    <= di_im_d;
      m_valid_q  <= m_valid_d;
      m_re_q     <= m_re_d;
      m_im_q     <= m_im_d;
      m_first_q  <= m_first_d;
      m_last_q   <= m_last_d;
      err_sp_q   <= err_sp_d;
      err_to_q   <= err_to_d;
    end
  end

  assign fft_di_en    = di_en_q;
  assign fft_di_re    = di_re_q;
  assign fft_di_im    = di_im_q;
  assign m_valid      = m_valid_q;
  assign m_re         = m_re_q;
  assign m_im         = m_im_q;
  assign m_first      = m_first_q;
  assign m_last       = m_last_q;
  assign inflight     = inflight_q;
  assign err_spurious = err_sp_q;
  assign err_timeout  = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_ctrl - directed self-checking bench for fft_frame_ctrl.
// Revision: 1.0
// ============================================================================
module tb_fft_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_re, s_im;
  logic        fft_di_en;
  logic [15:0] fft_di_re, fft_di_im;
  logic        fft_do_en;
  logic [15:0] fft_do_re, fft_do_im;
  logic        m_valid;
  logic [15:0] m_re, m_im;
  logic        m_first, m_last;
  logic [1:0]  inflight;
  logic        err_spurious, err_timeout;

  // Stand-in for the FFT core: either a zero-latency loopback or manual drive.
  logic        loop_en;
  logic        man_do_en;
  logic [15:0] man_do_re, man_do_im;

  int vectors     = 0;
  int miscompares = 0;

  assign fft_do_en = loop_en ? fft_di_en : man_do_en;
  assign fft_do_re = loop_en ? fft_di_re : man_do_re;
  assign fft_do_im = loop_en ? fft_di_im : man_do_im;

  always #5 clock = ~clock;

  fft_frame_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_re         (s_re),
    .s_im         (s_im),
    .fft_di_en    (fft_di_en),
    .fft_di_re    (fft_di_re),
    .fft_di_im    (fft_di_im),
    .fft_do_en    (fft_do_en),
    .fft_do_re    (fft_do_re),
    .fft_do_im    (fft_do_im),
    .m_valid      (m_valid),
    .m_re         (m_re),
    .m_im         (m_im),
    .m_first      (m_first),
    .m_last       (m_last),
    .inflight     (inflight),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    s_valid   = 1'b0;
    man_do_en = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic push_frame(input int base);
    for (int k = 0; k < 64; k++) begin
      s_valid = 1'b1;
      s_re    = 16'(base + k);
      s_im    = 16'(-(base + k));
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Loopback must be on. Checks burst timing, data order, markers and inflight.
  task automatic single_frame(input int base);
    logic [15:0] e_re, e_im;
    push_frame(base);
    chk("sf_no_early_burst", 32'(fft_di_en), 32'd0);
    for (int i = 0; i <= 64; i++) begin
      tick();
      chk("sf_di_en", 32'(fft_di_en), (i < 64) ? 32'd1 : 32'd0);
      if (i < 64) begin
        e_re = 16'(base + i);
        e_im = 16'(-(base + i));
        chk("sf_di_re", 32'(fft_di_re), 32'(e_re));
        chk("sf_di_im", 32'(fft_di_im), 32'(e_im));
      end
      chk("sf_m_valid", 32'(m_valid), (i >= 1) ? 32'd1 : 32'd0);
      if (i >= 1) begin
        e_re = 16'(base + i - 1);
        chk("sf_m_re", 32'(m_re), 32'(e_re));
      end
      chk("sf_m_first", 32'(m_first), (i == 1) ? 32'd1 : 32'd0);
      chk("sf_m_last", 32'(m_last), (i == 64) ? 32'd1 : 32'd0);
      chk("sf_inflight", 32'(inflight), (i < 64) ? 32'd1 : 32'd0);
      chk("sf_s_ready", 32'(s_ready), 32'd1);
    end
    tick();
    chk("sf_m_valid_after", 32'(m_valid), 32'd0);
    chk("sf_err_spurious", 32'(err_spurious), 32'd0);
    chk("sf_err_timeout", 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int bursts, gap, run, mv_cnt, mf_cnt, ml_cnt, rdy_drop, seq_err, di_exp, pushed, cyc;
    logic prev_en;

    loop_en   = 1'b1;
    man_do_en = 1'b0;
    man_do_re = '0;
    man_do_im = '0;
    s_re      = '0;
    s_im      = '0;

    // Reset state
    do_reset(5);
    chk("rst_di_en", 32'(fft_di_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_first", 32'(m_first), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err_spurious", 32'(err_spurious), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Single frame
    single_frame(0);

    // Continuous 256-sample stream
    do_reset(2);
    bursts = 0; run = 0; mv_cnt = 0; mf_cnt = 0; ml_cnt = 0;
    rdy_drop = 0; seq_err = 0; di_exp = 0; prev_en = 1'b0;
    for (int c = 0; c < 340; c++) begin
      s_valid = (c < 256);
      s_re    = 16'(c);
      s_im    = 16'(c);
      tick();
      if (c < 256 && !s_ready) rdy_drop++;
      if (fft_di_en) begin
        if (!prev_en) begin
          if (bursts > 0) chk("stream_gap", 32'(run), 32'd1);
          bursts++;
        end
        if (fft_di_re !== 16'(di_exp)) seq_err++;
        di_exp++;
        run = 0;
      end else begin
        run++;
      end
      prev_en = fft_di_en;
      if (m_valid) mv_cnt++;
      if (m_first) mf_cnt++;
      if (m_last) ml_cnt++;
    end
    s_valid = 1'b0;
    chk("stream_ready_drops", 32'(rdy_drop), 32'd0);
    chk("stream_bursts", 32'(bursts), 32'd4);
    chk("stream_di_count", 32'(di_exp), 32'd256);
    chk("stream_di_order", 32'(seq_err), 32'd0);
    chk("stream_m_valid", 32'(mv_cnt), 32'd256);
    chk("stream_m_first", 32'(mf_cnt), 32'd4);
    chk("stream_m_last", 32'(ml_cnt), 32'd4);
    chk("stream_inflight_end", 32'(inflight), 32'd0);

    // Backpressure: core output held off
    do_reset(2);
    loop_en = 1'b0;
    pushed = 0; cyc = 0; bursts = 0; prev_en = 1'b0;
    while (pushed < 256 && cyc < 600) begin
      s_valid = 1'b1;
      s_re    = 16'(pushed);
      if (s_ready) pushed++;
      tick();
      if (fft_di_en && !prev_en) bursts++;
      prev_en = fft_di_en;
      cyc++;
    end
    chk("bp_pushed", 32'(pushed), 32'd256);
    chk("bp_no_stall", 32'(cyc), 32'd256);
    rdy_drop = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_ready) rdy_drop++;
      if (fft_di_en && !prev_en) bursts++;
      prev_en = fft_di_en;
    end
    s_valid = 1'b0;
    chk("bp_ready_held_low", 32'(rdy_drop), 32'd0);
    chk("bp_bursts", 32'(bursts), 32'd2);
    chk("bp_inflight", 32'(inflight), 32'd2);
    chk("bp_di_en_blocked", 32'(fft_di_en), 32'd0);
    man_do_en = 1'b1;
    repeat (64) tick();
    man_do_en = 1'b0;
    chk("bp_drain_m_last", 32'(m_last), 32'd1);
    chk("bp_drain_inflight", 32'(inflight), 32'd1);
    chk("bp_drain_ready_still_low", 32'(s_ready), 32'd0);
    tick();
    chk("bp_third_burst", 32'(fft_di_en), 32'd1);
    chk("bp_third_inflight", 32'(inflight), 32'd2);
    chk("bp_ready_resumes", 32'(s_ready), 32'd1);

    // Spurious output
    do_reset(2);
    loop_en   = 1'b0;
    man_do_en = 1'b1;
    man_do_re = 16'h1234;
    man_do_im = 16'hBEEF;
    tick();
    man_do_en = 1'b0;
    chk("sp_m_valid", 32'(m_valid), 32'd1);
    chk("sp_m_first", 32'(m_first), 32'd1);
    chk("sp_m_last", 32'(m_last), 32'd0);
    chk("sp_m_re", 32'(m_re), 32'h1234);
    chk("sp_m_im", 32'(m_im), 32'hBEEF);
    chk("sp_err", 32'(err_spurious), 32'd1);
    chk("sp_inflight", 32'(inflight), 32'd0);
    tick();
    chk("sp_m_valid_once", 32'(m_valid), 32'd0);
    repeat (10) tick();
    chk("sp_err_sticky", 32'(err_spurious), 32'd1);
    do_reset(1);
    chk("sp_err_cleared", 32'(err_spurious), 32'd0);

    // Timeout: count starts on the edge that puts the frame in flight
    do_reset(2);
    loop_en = 1'b0;
    push_frame(0);
    tick();
    chk("to_burst_start", 32'(fft_di_en), 32'd1);
    chk("to_inflight", 32'(inflight), 32'd1);
    repeat (511) tick();
    chk("to_not_yet", 32'(err_timeout), 32'd0);
    tick();
    chk("to_set", 32'(err_timeout), 32'd1);
    repeat (20) tick();
    chk("to_sticky", 32'(err_timeout), 32'd1);
    do_reset(1);
    chk("to_cleared", 32'(err_timeout), 32'd0);

    // Reset mid-burst, then a fresh frame
    do_reset(2);
    loop_en = 1'b1;
    push_frame(200);
    tick();
    chk("mb_burst_start", 32'(fft_di_en), 32'd1);
    repeat (30) tick();
    chk("mb_cycle30", 32'(fft_di_re), 32'd230);
    do_reset(1);
    chk("mb_di_en", 32'(fft_di_en), 32'd0);
    chk("mb_s_ready", 32'(s_ready), 32'd1);
    chk("mb_inflight", 32'(inflight), 32'd0);
    chk("mb_m_valid", 32'(m_valid), 32'd0);
    single_frame(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
